xor_delta_decoder: RTL and testbench

- Receiving end of the 5-bit XOR-difference ("desigualdade") path. The upstream stage emits delta = current ^ previous per bit.
- This block rebuilds the original word stream by XOR-ing each incoming delta with a running reference register.
- Sits between the bitwise-difference operator stage and any consumer of the restored operand. Valid/ready handshake on both sides, one-entry output buffer.

---
 rtl/xor_delta_decoder_pkg.sv | 31 +++
 rtl/xor_delta_decoder_if.sv | 44 ++++
 rtl/xor_delta_decoder_xor_bits.sv | 24 ++
 rtl/xor_delta_decoder.sv | 99 +++++++++
 tb/tb_xor_delta_decoder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/xor_delta_decoder_pkg.sv
// ============================================================================
// Module   : xor_delta_pkg
// Purpose  : Shared constants, FSM encoding and popcount helper for the
//            XOR-delta decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package xor_delta_pkg;

  localparam int DELTA_WIDTH_DEFAULT = 5;
  localparam int POPCOUNT_MAX_W      = 32;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Callers zero-extend narrower words into the fixed-width argument.
  function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xor_delta_decoder_if.sv
// ============================================================================
// Module   : xor_delta_decoder_if
// Purpose  : Delta-in / word-out handshake bundle for xor_delta_decoder.
//            diff_bits exists only when XOR_DELTA_POPCOUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xor_delta_decoder_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
);

  logic             ref_clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_delta;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic [CNT_W-1:0] beat_cnt;
`ifdef XOR_DELTA_POPCOUNT_EN
  logic [$clog2(WIDTH+1)-1:0] diff_bits;
`endif

  modport master (
    output ref_clear, in_valid, in_delta, out_ready,
`ifdef XOR_DELTA_POPCOUNT_EN
    input  diff_bits,
`endif
    input  in_ready, out_valid, out_word, beat_cnt
  );

  modport slave (
    input  ref_clear, in_valid, in_delta, out_ready,
`ifdef XOR_DELTA_POPCOUNT_EN
    output diff_bits,
`endif
    output in_ready, out_valid, out_word, beat_cnt
  );

endinterface

`default_nettype wire

// File: rtl/xor_delta_decoder_xor_bits.sv
// ============================================================================
// Module   : delta_xor_bits
// Purpose  : Per-bit XOR array combining the running reference with a delta.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module delta_xor_bits #(
  parameter int WIDTH = 5
) (
  input  wire logic [WIDTH-1:0] ref_word,
  input  wire logic [WIDTH-1:0] delta,
  output logic      [WIDTH-1:0] result
);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign result[i] = ref_word[i] ^ delta[i];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/xor_delta_decoder.sv
// ============================================================================
// Module   : xor_delta_decoder
// Purpose  : Rebuilds a word stream from XOR deltas via a running reference,
//            with a one-entry output buffer. XOR_DELTA_POPCOUNT_EN adds
//            diff_bits (ones count of each accepted delta).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_delta_decoder
  import xor_delta_pkg::*;
#(
  parameter int               WIDTH    = DELTA_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] INIT_REF = '0,
  parameter int               CNT_W    = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  xor_delta_decoder_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] r_reference;
  logic [WIDTH-1:0] r_word;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [WIDTH-1:0] w_xor;

  delta_xor_bits #(.WIDTH(WIDTH)) u_xor_bits (
    .ref_word (r_reference),
    .delta    (bus.in_delta),
    .result   (w_xor)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b1;
    w_accept    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_in_ready = 1'b1;
        w_accept   = bus.in_valid;
        if (bus.in_valid) w_state_nxt = ST_FULL;
      end
      ST_FULL: begin
        // The buffer slot frees up in the same cycle the consumer takes it.
        w_in_ready = bus.out_ready;
        w_accept   = bus.in_valid & bus.out_ready;
        if (bus.out_ready && !bus.in_valid) w_state_nxt = ST_EMPTY;
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reference <= INIT_REF;
      r_word      <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_word     <= w_xor;
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      // A clear still lets the accepted beat decode against the old reference.
      if (bus.ref_clear)  r_reference <= INIT_REF;
      else if (w_accept)  r_reference <= w_xor;
    end
  end

`ifdef XOR_DELTA_POPCOUNT_EN
  localparam int DB_W = $clog2(WIDTH+1);
  logic [DB_W-1:0] r_diff_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_diff_bits <= '0;
    else if (w_accept) r_diff_bits <= DB_W'(popcount(POPCOUNT_MAX_W'(bus.in_delta)));
  end

  assign bus.diff_bits = r_diff_bits;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_word  = r_word;
  assign bus.beat_cnt  = r_beat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_xor_delta_decoder.sv
// ============================================================================
// Module   : tb_xor_delta_decoder
// Purpose  : Self-checking bench for xor_delta_decoder (vector table, corner
//            sequences, randomized stream against an encoder/queue model).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_xor_delta_decoder;

  localparam int W  = 5;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  xor_delta_decoder_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  xor_delta_decoder #(.WIDTH(W), .INIT_REF(5'b00000), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    bus.in_valid  = 1'b0;
    bus.in_delta  = '0;
    bus.ref_clear = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [W-1:0]  delta;
    logic          clr;
    logic [W-1:0]  exp_word;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t tbl [8];

  logic [W-1:0]  prev, ref_m, buf_m, cur_word;
  logic [CW-1:0] cnt_m;
  bit            occ, pend, exp_rdy, acc, drain;

  initial begin
    tbl[0] = '{5'b00001, 1'b0, 5'b00001, 8'd1};
    tbl[1] = '{5'b00011, 1'b0, 5'b00010, 8'd2};
    tbl[2] = '{5'b00000, 1'b0, 5'b00010, 8'd3};
    tbl[3] = '{5'b11111, 1'b0, 5'b11101, 8'd4};
    tbl[4] = '{5'b00110, 1'b1, 5'b11011, 8'd5};
    tbl[5] = '{5'b00001, 1'b0, 5'b00001, 8'd6};
    tbl[6] = '{5'b10100, 1'b0, 5'b10101, 8'd7};
    tbl[7] = '{5'b11111, 1'b0, 5'b01010, 8'd8};

    reset_dut();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_word",  32'(bus.out_word),  32'd0);
    check("rst_beat_cnt",  32'(bus.beat_cnt),  32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
`ifdef XOR_DELTA_POPCOUNT_EN
    check("rst_diff_bits", 32'(bus.diff_bits), 32'd0);
`endif

    // Streaming table, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_delta  = tbl[i].delta;
      bus.ref_clear = tbl[i].clr;
      tick();
      check($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("tbl%0d_word", i),  32'(bus.out_word),  32'(tbl[i].exp_word));
      check($sformatf("tbl%0d_cnt", i),   32'(bus.beat_cnt),  32'(tbl[i].exp_cnt));
`ifdef XOR_DELTA_POPCOUNT_EN
      check($sformatf("tbl%0d_diff", i),  32'(bus.diff_bits), 32'($countones(tbl[i].delta)));
`endif
    end
    bus.in_valid  = 1'b0;
    bus.ref_clear = 1'b0;
    tick();
    check("tbl_drain_valid", 32'(bus.out_valid), 32'd0);

    // Full-range sweep through a golden encoder.
    reset_dut();
    prev = '0;
    for (int w = 0; w < 32; w++) begin
      bus.in_valid = 1'b1;
      bus.in_delta = 5'(w) ^ prev;
      prev         = 5'(w);
      tick();
      check($sformatf("sweep%0d", w), 32'(bus.out_word), 32'(w));
    end
    bus.in_delta = 5'b00000;
    tick();
    check("sweep_final_ref", 32'(bus.out_word), 32'd31);
    check("sweep_cnt",       32'(bus.beat_cnt), 32'd33);

    // Backpressure while a new delta waits.
    bus.out_ready = 1'b0;
    bus.in_delta  = 5'b00101;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("bp%0d_in_ready", k), 32'(bus.in_ready),  32'd0);
      check($sformatf("bp%0d_valid", k),    32'(bus.out_valid), 32'd1);
      check($sformatf("bp%0d_word", k),     32'(bus.out_word),  32'd31);
      check($sformatf("bp%0d_cnt", k),      32'(bus.beat_cnt),  32'd33);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_release_word", 32'(bus.out_word), 32'(5'd31 ^ 5'b00101));
    check("bp_release_cnt",  32'(bus.beat_cnt), 32'd34);
    bus.in_valid = 1'b0;
    tick();
    check("bp_drain_valid", 32'(bus.out_valid), 32'd0);

    // ref_clear coinciding with an accept.
    reset_dut();
    bus.in_valid = 1'b1;
    bus.in_delta = 5'b10101;
    tick();
    bus.in_delta  = 5'b00110;
    bus.ref_clear = 1'b1;
    tick();
    check("clr_old_ref_word", 32'(bus.out_word), 32'b10011);
    bus.ref_clear = 1'b0;
    bus.in_delta  = 5'b00001;
    tick();
    check("clr_new_ref_word", 32'(bus.out_word), 32'b00001);
    // Clear without accept leaves out_word alone.
    bus.in_valid  = 1'b0;
    bus.ref_clear = 1'b1;
    tick();
    check("clr_only_word", 32'(bus.out_word), 32'b00001);
    bus.ref_clear = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_delta  = 5'b00100;
    tick();
    check("clr_only_next", 32'(bus.out_word), 32'b00100);
    bus.in_valid = 1'b0;
    tick();

    // Async reset in the middle of a stall.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_delta  = 5'b00011;
    tick();
    bus.in_valid = 1'b0;
    check("stall_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_cnt",   32'(bus.beat_cnt),  32'd0);
    check("async_rst_word",  32'(bus.out_word),  32'd0);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_delta  = 5'b01000;
    tick();
    check("post_rst_word", 32'(bus.out_word), 32'b01000);
    bus.in_valid = 1'b0;
    tick();

    // Beat counter wrap.
    reset_dut();
    bus.in_valid = 1'b1;
    bus.in_delta = 5'b00000;
    repeat (255) tick();
    check("cnt_255", 32'(bus.beat_cnt), 32'd255);
    tick();
    check("cnt_wrap", 32'(bus.beat_cnt), 32'd0);
    bus.in_valid = 1'b0;
    tick();

    // Randomized stream: random words are encoded, then expected back in order.
    reset_dut();
    ref_m = '0;
    occ   = 1'b0;
    pend  = 1'b0;
    cnt_m = '0;
    cur_word = '0;
    buf_m    = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        cur_word = 5'($urandom);
        pend     = 1'b1;
      end
      bus.in_valid  = pend;
      bus.in_delta  = cur_word ^ ref_m;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = !occ || bus.out_ready;
      check("rnd_in_ready",  32'(bus.in_ready),  32'(exp_rdy));
      check("rnd_out_valid", 32'(bus.out_valid), 32'(occ));
      if (occ) check("rnd_out_word", 32'(bus.out_word), 32'(buf_m));
      acc   = pend && exp_rdy;
      drain = occ && bus.out_ready;
      tick();
      if (drain) occ = 1'b0;
      if (acc) begin
        buf_m = cur_word;
        ref_m = cur_word;
        occ   = 1'b1;
        pend  = 1'b0;
        cnt_m = cnt_m + 1'b1;
      end
      check("rnd_beat_cnt", 32'(bus.beat_cnt), 32'(cnt_m));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
